// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared fetch-stage constants, queue entry type and PC helper.
// Revision : 1.0
// ============================================================================
package if_fetch_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEna     = 1'b1;
  localparam logic        ChipDisa    = 1'b0;
  localparam int          DefQDepth   = 4;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Instruction fetches are word granular; low address bits are dropped.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Circular fetch queue with push/pop/flush and a zeroed head when empty.
// Revision : 1.0
// ============================================================================
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int QDEPTH = DefQDepth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(QDEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_w, pop_w;
  fetch_entry_t  mem_q [QDEPTH];

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign push_w  = push_i & ~full_o & ~flush_i;
  assign pop_w   = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_w) wptr_d = wptr_q + 1'b1;
      if (pop_w)  rptr_d = rptr_q + 1'b1;
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o = empty_o ? fetch_entry_t'({ZeroWord, ZeroWord}) : mem_q[rptr_q];

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : PC generation and ROM enable feeding a decoupling fetch queue.
// Revision : 1.0
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int QDEPTH = DefQDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_addr_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic                   ce_o,
  input  logic [InstBus-1:0]     inst_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o
);

  logic                   ce_q;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   full_w, empty_w;
  logic                   push_w, pop_w;
  fetch_entry_t           wdata_w, head_w;

  // Full is the start-of-cycle state, so a same-cycle pop never frees a slot.
  assign push_w  = (ce_q == ChipEna) & ~stall & ~branch_flag_i & ~full_w;
  assign pop_w   = ~empty_w & id_ready_i & ~branch_flag_i;
  assign wdata_w = '{pc: pc_q, inst: inst_i};

  always_comb begin
    pc_d = pc_q;
    if (ce_q == ChipDisa) begin
      pc_d = ZeroWord;
    end else if (branch_flag_i) begin
      pc_d = word_align(branch_target_addr_i);
    end else if (push_w) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q <= ChipDisa;
      pc_q <= ZeroWord;
    end else begin
      ce_q <= ChipEna;
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .flush_i (branch_flag_i),
    .wdata_i (wdata_w),
    .full_o  (full_w),
    .empty_o (empty_w),
    .head_o  (head_w)
  );

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign id_valid_o = ~empty_w;
  assign id_pc_o    = head_w.pc;
  assign id_inst_o  = head_w.inst;

endmodule
`default_nettype wire
